spin_iq_block_averager: RTL and testbench

Downstream consumer of the AD9361 receive path in the spin sensor design. Takes the interface's I0/Q0 sample strobes and data on the interface clock, pairs each I with its Q, and sums 2^log2_n pairs. It emits one averaged I/Q result per block over a valid/ready output, held in a single-entry buffer. Overflow and pairing errors are flagged with sticky bits for software.

---
 rtl/spin_iq_block_averager.sv | 195 +++++++++++++++++++
 tb/tb_spin_iq_block_averager.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spin_iq_block_averager.sv
`default_nettype none
// ============================================================================
//  Module      : spin_iq_block_averager
//  Description : Pairs I/Q sample strobes from the AD9361 receive interface,
//                sums 2^n pairs per block and emits the floor-average of each
//                block through a single-entry valid/ready buffer. Overflow and
//                pairing errors are reported as sticky flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module spin_iq_block_averager #(
   parameter int DATA_WIDTH = 16,
   parameter int LOG2_N_MAX = 8
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         adc_valid_i,
   input  logic signed [DATA_WIDTH-1:0] adc_data_i,
   input  logic                         adc_valid_q,
   input  logic signed [DATA_WIDTH-1:0] adc_data_q,
   input  logic                         cfg_enable,
   input  logic [3:0]                   cfg_log2_n,
   input  logic                         clr_status,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data_i,
   output logic signed [DATA_WIDTH-1:0] out_data_q,
   output logic                         ovf_sticky,
   output logic                         pair_err_sticky
);

   localparam int c_ACC_W = DATA_WIDTH + LOG2_N_MAX;
   localparam int c_CNT_W = (LOG2_N_MAX > 0) ? LOG2_N_MAX : 1;
   localparam int c_LIM_W = c_CNT_W + 1;
   localparam logic [4:0]         c_NMAX    = 5'(LOG2_N_MAX);
   localparam logic [c_LIM_W-1:0] c_LIM_ONE = c_LIM_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

   typedef enum logic [0:0] {
      WAIT_I = 1'b0,
      WAIT_Q = 1'b1
   } state_t;

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic signed [DATA_WIDTH-1:0]  r_lat_i;
   logic signed [DATA_WIDTH-1:0]  w_lat_i_nxt;
   logic                          w_pair;
   logic                          w_pair_err;
   logic signed [DATA_WIDTH-1:0]  w_pair_i;
   logic signed [DATA_WIDTH-1:0]  w_pair_q;

   logic [c_CNT_W-1:0]            r_cnt;
   logic [3:0]                    r_n;
   logic [3:0]                    w_n_clamp;
   logic [3:0]                    w_n_use;
   logic [c_LIM_W-1:0]            w_limit;
   logic                          w_last;
   logic                          w_result;
   logic                          w_ovf_set;

   logic signed [c_ACC_W-1:0]     r_acc_i;
   logic signed [c_ACC_W-1:0]     r_acc_q;
   logic signed [c_ACC_W-1:0]     w_sum_i;
   logic signed [c_ACC_W-1:0]     w_sum_q;
   logic signed [c_ACC_W-1:0]     w_avg_i;
   logic signed [c_ACC_W-1:0]     w_avg_q;

   // Pairing decode: decide whether this cycle completes a pair, what the pair is,
   // and how the pending-I holder and state move. Disabled means flush to WAIT_I.
   always_comb begin
      w_state_nxt = r_state;
      w_lat_i_nxt = r_lat_i;
      w_pair      = 1'b0;
      w_pair_err  = 1'b0;
      w_pair_i    = adc_data_i;
      w_pair_q    = adc_data_q;
      if (!cfg_enable) begin
         w_state_nxt = WAIT_I;
         w_lat_i_nxt = '0;
      end else begin
         case (r_state)
            WAIT_I: begin
               if (adc_valid_i && adc_valid_q) begin
                  w_pair = 1'b1;
               end else if (adc_valid_i) begin
                  w_lat_i_nxt = adc_data_i;
                  w_state_nxt = WAIT_Q;
               end else if (adc_valid_q) begin
                  w_pair_err = 1'b1;
               end
            end
            WAIT_Q: begin
               if (adc_valid_q) begin
                  // Latched I pairs with this Q; a simultaneous I becomes the new pending I.
                  w_pair   = 1'b1;
                  w_pair_i = r_lat_i;
                  if (adc_valid_i) begin
                     w_lat_i_nxt = adc_data_i;
                  end else begin
                     w_state_nxt = WAIT_I;
                  end
               end else if (adc_valid_i) begin
                  w_lat_i_nxt = adc_data_i;
                  w_pair_err  = 1'b1;
               end
            end
            default: begin
               w_state_nxt = WAIT_I;
            end
         endcase
      end
   end

   // Pairing state and pending-I register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= WAIT_I;
         r_lat_i <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lat_i <= w_lat_i_nxt;
      end
   end

   // Block length is taken from the config only at the first pair of a block.
   assign w_n_clamp = ({1'b0, cfg_log2_n} > c_NMAX) ? c_NMAX[3:0] : cfg_log2_n;
   assign w_n_use   = (r_cnt == '0) ? w_n_clamp : r_n;
   assign w_limit   = c_LIM_ONE << w_n_use;
   assign w_last    = ({1'b0, r_cnt} == (w_limit - c_LIM_ONE));
   assign w_result  = w_pair && w_last;
   assign w_ovf_set = w_result && out_valid && !out_ready;

   assign w_sum_i   = r_acc_i + {{LOG2_N_MAX{w_pair_i[DATA_WIDTH-1]}}, w_pair_i};
   assign w_sum_q   = r_acc_q + {{LOG2_N_MAX{w_pair_q[DATA_WIDTH-1]}}, w_pair_q};
   assign w_avg_i   = w_sum_i >>> w_n_use;
   assign w_avg_q   = w_sum_q >>> w_n_use;

   // Accumulate pairs; the final pair of a block restarts the accumulators.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_acc_i <= '0;
         r_acc_q <= '0;
         r_cnt   <= '0;
         r_n     <= '0;
      end else if (!cfg_enable) begin
         r_acc_i <= '0;
         r_acc_q <= '0;
         r_cnt   <= '0;
      end else if (w_pair) begin
         if (r_cnt == '0) begin
            r_n <= w_n_clamp;
         end
         if (w_last) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_cnt   <= '0;
         end else begin
            r_acc_i <= w_sum_i;
            r_acc_q <= w_sum_q;
            r_cnt   <= r_cnt + c_CNT_ONE;
         end
      end
   end

   // Single-entry output buffer; a full, stalled buffer drops the new result.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid  <= 1'b0;
         out_data_i <= '0;
         out_data_q <= '0;
      end else if (w_result && !(out_valid && !out_ready)) begin
         out_valid  <= 1'b1;
         out_data_i <= w_avg_i[DATA_WIDTH-1:0];
         out_data_q <= w_avg_q[DATA_WIDTH-1:0];
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

   // Sticky error flags; a new error in the clearing cycle wins.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovf_sticky      <= 1'b0;
         pair_err_sticky <= 1'b0;
      end else if (clr_status) begin
         ovf_sticky      <= w_ovf_set;
         pair_err_sticky <= w_pair_err;
      end else begin
         ovf_sticky      <= ovf_sticky | w_ovf_set;
         pair_err_sticky <= pair_err_sticky | w_pair_err;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spin_iq_block_averager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spin_iq_block_averager
//  Description : Self-checking bench for spin_iq_block_averager with a
//                behavioural block-average reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spin_iq_block_averager;

   logic              clk;
   logic              resetn;
   logic              adc_valid_i;
   logic signed [15:0] adc_data_i;
   logic              adc_valid_q;
   logic signed [15:0] adc_data_q;
   logic              cfg_enable;
   logic [3:0]        cfg_log2_n;
   logic              clr_status;
   logic              out_valid;
   logic              out_ready;
   logic signed [15:0] out_data_i;
   logic signed [15:0] out_data_q;
   logic              ovf_sticky;
   logic              pair_err_sticky;

   int n_total;
   int n_bad;

   // reference model state
   bit     m_pend;
   int     m_pend_i;
   int     m_cnt;
   longint m_si;
   longint m_sq;
   int     m_n;
   bit     m_valid;
   int     m_oi;
   int     m_oq;
   bit     m_ovf;
   bit     m_perr;

   spin_iq_block_averager #(
      .DATA_WIDTH (16),
      .LOG2_N_MAX (8)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .adc_valid_i     (adc_valid_i),
      .adc_data_i      (adc_data_i),
      .adc_valid_q     (adc_valid_q),
      .adc_data_q      (adc_data_q),
      .cfg_enable      (cfg_enable),
      .cfg_log2_n      (cfg_log2_n),
      .clr_status      (clr_status),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data_i      (out_data_i),
      .out_data_q      (out_data_q),
      .ovf_sticky      (ovf_sticky),
      .pair_err_sticky (pair_err_sticky)
   );

   always #5 clk = ~clk;

   function automatic int floordiv(input longint s, input int n);
      longint d;
      longint q;
      d = longint'(1) << n;
      q = s / d;
      if ((q * d) != s && s < 0) q = q - 1;
      return int'(q);
   endfunction

   task automatic model_reset();
      m_pend = 0; m_pend_i = 0; m_cnt = 0; m_si = 0; m_sq = 0; m_n = 0;
      m_valid = 0; m_oi = 0; m_oq = 0; m_ovf = 0; m_perr = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit got = 0;
      bit err = 0;
      bit res = 0;
      bit ovfset;
      int pi = 0;
      int pq = 0;
      int ri = 0;
      int rq = 0;
      if (!cfg_enable) begin
         m_pend = 0; m_cnt = 0; m_si = 0; m_sq = 0;
      end else if (!m_pend) begin
         if (adc_valid_i && adc_valid_q) begin
            got = 1; pi = adc_data_i; pq = adc_data_q;
         end else if (adc_valid_i) begin
            m_pend = 1; m_pend_i = adc_data_i;
         end else if (adc_valid_q) begin
            err = 1;
         end
      end else begin
         if (adc_valid_q) begin
            got = 1; pi = m_pend_i; pq = adc_data_q;
            if (adc_valid_i) m_pend_i = adc_data_i;
            else m_pend = 0;
         end else if (adc_valid_i) begin
            m_pend_i = adc_data_i; err = 1;
         end
      end
      if (got) begin
         if (m_cnt == 0) m_n = (cfg_log2_n > 8) ? 8 : int'(cfg_log2_n);
         m_si = m_si + pi;
         m_sq = m_sq + pq;
         m_cnt++;
         if (m_cnt == (1 << m_n)) begin
            res = 1;
            ri = floordiv(m_si, m_n);
            rq = floordiv(m_sq, m_n);
            m_cnt = 0; m_si = 0; m_sq = 0;
         end
      end
      ovfset = res && m_valid && !out_ready;
      if (ovfset) begin
         // buffer keeps its contents
      end else if (res) begin
         m_valid = 1; m_oi = ri; m_oq = rq;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      if (clr_status) begin m_ovf = 0; m_perr = 0; end
      if (ovfset) m_ovf = 1;
      if (err) m_perr = 1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit vi, input int di, input bit vq, input int dq);
      adc_valid_i = vi;
      adc_data_i  = 16'(di);
      adc_valid_q = vq;
      adc_data_q  = 16'(dq);
   endtask

   task automatic test_reset();
      resetn = 1; cfg_enable = 1; cfg_log2_n = 0; clr_status = 0; out_ready = 1;
      set_in(0, 0, 0, 0);
      #2 resetn = 0;
      #1;
      n_total++;
      if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !== 35'd0) begin
         n_bad++;
         $display("FAIL reset: got v=%0b i=%0d q=%0d ovf=%0b perr=%0b, want all zero",
                  out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky);
      end
      repeat (2) @(posedge clk);
      #1 resetn = 1;
      model_reset();
      tick();
      n_total++;
      if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !==
          {m_valid, m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
         n_bad++;
         $display("FAIL reset_idle: got v=%0b i=%0d q=%0d, want v=%0b i=%0d q=%0d",
                  out_valid, out_data_i, out_data_q, m_valid, m_oi, m_oq);
      end
   endtask

   task automatic test_basic();
      cfg_log2_n = 2; out_ready = 1;
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) set_in(1, 4 * k, 1, -4 * k);
         else set_in(0, 0, 0, 0);
         tick();
         n_total++;
         if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !==
             {m_valid, m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
            n_bad++;
            $display("FAIL basic c%0d: got v=%0b i=%0d q=%0d ovf=%0b perr=%0b, want v=%0b i=%0d q=%0d ovf=%0b perr=%0b",
                     k, out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky,
                     m_valid, m_oi, m_oq, m_ovf, m_perr);
         end
         n_total++;
         if (k == 4 && !(out_valid === 1'b1 && out_data_i === 16'sd10 && out_data_q === -16'sd10)) begin
            n_bad++;
            $display("FAIL basic_avg: got v=%0b i=%0d q=%0d, want v=1 i=10 q=-10", out_valid, out_data_i, out_data_q);
         end else if (k != 4 && out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_pulse c%0d: got v=%0b, want v=0", k, out_valid);
         end
      end
   endtask

   task automatic test_floor();
      cfg_log2_n = 1; out_ready = 1;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: set_in(1, -3, 0, 0);
            1: set_in(0, 0, 1, 5);
            2: set_in(1, -2, 0, 0);
            3: set_in(0, 0, 1, 6);
            default: set_in(0, 0, 0, 0);
         endcase
         tick();
         n_total++;
         if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !==
             {m_valid, m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
            n_bad++;
            $display("FAIL floor c%0d: got v=%0b i=%0d q=%0d perr=%0b, want v=%0b i=%0d q=%0d perr=%0b",
                     k, out_valid, out_data_i, out_data_q, pair_err_sticky, m_valid, m_oi, m_oq, m_perr);
         end
         if (k == 3) begin
            n_total++;
            if (!(out_valid === 1'b1 && out_data_i === -16'sd3 && out_data_q === 16'sd5 && pair_err_sticky === 1'b0)) begin
               n_bad++;
               $display("FAIL floor_avg: got v=%0b i=%0d q=%0d perr=%0b, want v=1 i=-3 q=5 perr=0",
                        out_valid, out_data_i, out_data_q, pair_err_sticky);
            end
         end
      end
   endtask

   task automatic test_ovf();
      cfg_log2_n = 0; out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) set_in(1, 1, 1, 2);
         else if (k == 1) set_in(1, 3, 1, 4);
         else begin set_in(0, 0, 0, 0); out_ready = 1; end
         tick();
         n_total++;
         if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !==
             {m_valid, m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
            n_bad++;
            $display("FAIL ovf c%0d: got v=%0b i=%0d q=%0d ovf=%0b, want v=%0b i=%0d q=%0d ovf=%0b",
                     k, out_valid, out_data_i, out_data_q, ovf_sticky, m_valid, m_oi, m_oq, m_ovf);
         end
         if (k == 1) begin
            n_total++;
            if (!(out_valid === 1'b1 && out_data_i === 16'sd1 && out_data_q === 16'sd2 && ovf_sticky === 1'b1)) begin
               n_bad++;
               $display("FAIL ovf_hold: got v=%0b i=%0d q=%0d ovf=%0b, want v=1 i=1 q=2 ovf=1",
                        out_valid, out_data_i, out_data_q, ovf_sticky);
            end
         end
         if (k == 2) begin
            n_total++;
            if (out_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL ovf_drain: got v=%0b, want v=0", out_valid);
            end
         end
      end
   endtask

   task automatic test_pair_err();
      cfg_log2_n = 0; out_ready = 1;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: set_in(0, 0, 1, 5);
            1: set_in(1, 7, 0, 0);
            2: set_in(1, 9, 0, 0);
            3: set_in(0, 0, 1, 1);
            default: begin set_in(0, 0, 0, 0); clr_status = 1; end
         endcase
         tick();
         clr_status = 0;
         n_total++;
         if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !==
             {m_valid, m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
            n_bad++;
            $display("FAIL pairerr c%0d: got v=%0b i=%0d q=%0d ovf=%0b perr=%0b, want v=%0b i=%0d q=%0d ovf=%0b perr=%0b",
                     k, out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky,
                     m_valid, m_oi, m_oq, m_ovf, m_perr);
         end
         if (k == 3) begin
            n_total++;
            if (!(out_valid === 1'b1 && out_data_i === 16'sd9 && out_data_q === 16'sd1 && pair_err_sticky === 1'b1)) begin
               n_bad++;
               $display("FAIL pairerr_res: got v=%0b i=%0d q=%0d perr=%0b, want v=1 i=9 q=1 perr=1",
                        out_valid, out_data_i, out_data_q, pair_err_sticky);
            end
         end
         if (k == 4) begin
            n_total++;
            if (pair_err_sticky !== 1'b0 || ovf_sticky !== 1'b0) begin
               n_bad++;
               $display("FAIL clr_status: got perr=%0b ovf=%0b, want 0 0", pair_err_sticky, ovf_sticky);
            end
         end
      end
   endtask

   task automatic test_flush();
      int pulses = 0;
      cfg_log2_n = 3; out_ready = 1;
      for (int k = 0; k < 16; k++) begin
         cfg_enable = 1;
         if (k < 5) set_in(1, $urandom, 1, $urandom);
         else if (k == 5) begin cfg_enable = 0; set_in($urandom_range(0, 1), $urandom, 1, $urandom); end
         else if (k < 14) set_in(1, 100, 1, 100);
         else set_in(0, 0, 0, 0);
         tick();
         if (k >= 5 && out_valid) pulses++;
         n_total++;
         if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !==
             {m_valid, m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
            n_bad++;
            $display("FAIL flush c%0d: got v=%0b i=%0d q=%0d, want v=%0b i=%0d q=%0d",
                     k, out_valid, out_data_i, out_data_q, m_valid, m_oi, m_oq);
         end
         if (k == 13) begin
            n_total++;
            if (!(out_valid === 1'b1 && out_data_i === 16'sd100 && out_data_q === 16'sd100)) begin
               n_bad++;
               $display("FAIL flush_avg: got v=%0b i=%0d q=%0d, want v=1 i=100 q=100", out_valid, out_data_i, out_data_q);
            end
         end
      end
      cfg_enable = 1;
      n_total++;
      if (pulses != 1) begin
         n_bad++;
         $display("FAIL flush_pulses: got %0d results, want 1", pulses);
      end
   endtask

   task automatic test_back_to_back();
      cfg_log2_n = 0; out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         set_in(1, $urandom, 1, $urandom);
         tick();
         n_total++;
         if (out_valid !== 1'b1 ||
             {out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !== {m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
            n_bad++;
            $display("FAIL b2b c%0d: got v=%0b i=%0d q=%0d ovf=%0b, want v=1 i=%0d q=%0d ovf=%0b",
                     k, out_valid, out_data_i, out_data_q, ovf_sticky, m_oi, m_oq, m_ovf);
         end
      end
      set_in(0, 0, 0, 0);
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 2000; k++) begin
         set_in($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom);
         out_ready  = ($urandom_range(0, 9) < 7);
         cfg_enable = ($urandom_range(0, 59) != 0);
         clr_status = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 19) == 0)
            cfg_log2_n = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 3));
         tick();
         n_total++;
         if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !==
             {m_valid, m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
            n_bad++;
            $display("FAIL random c%0d: got v=%0b i=%0d q=%0d ovf=%0b perr=%0b, want v=%0b i=%0d q=%0d ovf=%0b perr=%0b",
                     k, out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky,
                     m_valid, m_oi, m_oq, m_ovf, m_perr);
         end
      end
      cfg_enable = 1; clr_status = 0; out_ready = 1;
      set_in(0, 0, 0, 0);
      tick();
   endtask

   task automatic test_async_reset();
      cfg_log2_n = 3; out_ready = 0;
      for (int k = 0; k < 12; k++) begin
         if (k < 11) set_in(1, $urandom, 1, $urandom);
         else set_in(0, 0, 0, 0);
         tick();
         n_total++;
         if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !==
             {m_valid, m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
            n_bad++;
            $display("FAIL pre_reset c%0d: got v=%0b i=%0d q=%0d, want v=%0b i=%0d q=%0d",
                     k, out_valid, out_data_i, out_data_q, m_valid, m_oi, m_oq);
         end
      end
      #3 resetn = 0;
      set_in(0, 0, 0, 0);
      #1;
      n_total++;
      if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !== 35'd0) begin
         n_bad++;
         $display("FAIL async_reset: got v=%0b i=%0d q=%0d ovf=%0b perr=%0b, want all zero",
                  out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky);
      end
      model_reset();
      @(posedge clk);
      #1 resetn = 1;
      out_ready = 1;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) set_in(1, $urandom, 1, $urandom);
         else set_in(0, 0, 0, 0);
         tick();
         n_total++;
         if ({out_valid, out_data_i, out_data_q, ovf_sticky, pair_err_sticky} !==
             {m_valid, m_oi[15:0], m_oq[15:0], m_ovf, m_perr}) begin
            n_bad++;
            $display("FAIL post_reset c%0d: got v=%0b i=%0d q=%0d, want v=%0b i=%0d q=%0d",
                     k, out_valid, out_data_i, out_data_q, m_valid, m_oi, m_oq);
         end
      end
   endtask

   initial begin
      clk = 0;
      n_total = 0;
      n_bad = 0;
      model_reset();
      test_reset();
      test_basic();
      test_floor();
      test_ovf();
      test_pair_err();
      test_flush();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
